// File: rtl/writeback_queue.sv
// writeback_queue
//   FIFO of (register index, byte) write-backs draining into an 8 x 8-bit
//   register bank through a registered output stage. One entry is issued per
//   cycle while drain_stall is low and the queue holds entries.
//
//   Optional feature: define WRITEBACK_BYPASS_EN to build the read bypass
//   (rd_hit/rd_data report the youngest pending write to rd_addr). Without
//   the macro rd_hit and rd_data are tied to zero.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_ready = count < DEPTH
//   in_addr, in_data    destination register index and byte
//   drain_stall         blocks issue to the register bank
//   reg_we, reg_data    one-hot write enable pulse and shared data bus
//   rd_addr             register index being read by the consumer
//   rd_hit, rd_data     bypass result
//   count               queued entries, excluding the output stage
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_addr,
    input  logic [7:0] in_data,
    input  logic       drain_stall,
    output logic [7:0] reg_we,
    output logic [7:0] reg_data,
    input  logic [2:0] rd_addr,
    output logic       rd_hit,
    output logic [7:0] rd_data,
    output logic [3:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic            out_valid_q, out_valid_d;
    entry_t          out_q, out_d;

    logic            push;
    logic            pop;

    // in_ready looks only at the stored count, never at a same-cycle pop.
    assign in_ready = (count_q < 4'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != 4'd0) && !drain_stall;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = pop;
        out_d       = out_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{addr: in_addr, data: in_data};
            // DEPTH is a power of two, so natural overflow wraps modulo DEPTH.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        // Output stage data holds its last value when nothing is issued.
        if (pop) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign reg_we   = out_valid_q ? (8'd1 << out_q.addr) : '0;
    assign reg_data = out_q.data;
    assign count    = count_q;

`ifdef WRITEBACK_BYPASS_EN
    logic          byp_hit;
    logic [7:0]    byp_data;
    logic [PW-1:0] byp_idx;

    // Output stage is checked first; queue entries are then scanned oldest
    // to youngest so the youngest match overrides everything before it.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        if (out_valid_q && (out_q.addr == rd_addr)) begin
            byp_hit  = 1'b1;
            byp_data = out_q.data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr_q + PW'(i);
            if ((i < 32'(count_q)) && (mem_q[byp_idx].addr == rd_addr)) begin
                byp_hit  = 1'b1;
                byp_data = mem_q[byp_idx].data;
            end
        end
    end

    assign rd_hit  = byp_hit;
    assign rd_data = byp_data;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_addr;
    logic [7:0] in_data;
    logic       drain_stall;
    logic [7:0] reg_we;
    logic [7:0] reg_data;
    logic [2:0] rd_addr;
    logic       rd_hit;
    logic [7:0] rd_data;
    logic [3:0] count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .drain_stall(drain_stall),
        .reg_we     (reg_we),
        .reg_data   (reg_data),
        .rd_addr    (rd_addr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
        .count      (count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of pending writes plus what was issued
    // at the last edge.
    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_we;
    logic [7:0] m_data;
    logic [2:0] m_iss_addr;
    bit         model_valid = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_model();
        logic       e_hit;
        logic [7:0] e_rd;
        e_hit = 1'b0;
        e_rd  = 8'h00;
`ifdef WRITEBACK_BYPASS_EN
        if (m_we != 8'h00 && m_iss_addr == rd_addr) begin
            e_hit = 1'b1;
            e_rd  = m_data;
        end
        foreach (mq[i]) begin
            if (mq[i].addr == rd_addr) begin
                e_hit = 1'b1;
                e_rd  = mq[i].data;
            end
        end
`endif
        chk("model in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("model count",    32'(count),    32'(mq.size()));
        chk("model reg_we",   32'(reg_we),   32'(m_we));
        chk("model reg_data", 32'(reg_data), 32'(m_data));
        chk("model rd_hit",   32'(rd_hit),   32'(e_hit));
        chk("model rd_data",  32'(rd_data),  32'(e_rd));
    endfunction

    function automatic void model_update();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_we        = 8'h00;
            m_data      = 8'h00;
            m_iss_addr  = 3'd0;
            model_valid = 1;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && !drain_stall;
            if (do_pop) begin
                e          = mq.pop_front();
                m_we       = 8'h01 << e.addr;
                m_data     = e.data;
                m_iss_addr = e.addr;
            end else begin
                m_we = 8'h00;
            end
            if (do_push) begin
                e.addr = in_addr;
                e.data = in_data;
                mq.push_back(e);
            end
        end
    endfunction

    // Check pre-edge outputs against the model, advance the model across the
    // coming edge, then return just after the edge for new stimulus.
    task automatic step();
        @(negedge clock);
        if (model_valid) check_model();
        model_update();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         v;
        logic [2:0] a;
        logic [7:0] d;
        bit         st;
        logic [7:0] we;
        logic [7:0] dat;
        logic [3:0] cnt;
        bit         rdy;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v, logic [2:0] a, logic [7:0] d, bit st,
                                logic [7:0] we, logic [7:0] dat, logic [3:0] cnt, bit rdy);
        vec_t r;
        r.rst = rst; r.v = v; r.a = a; r.d = d; r.st = st;
        r.we = we; r.dat = dat; r.cnt = cnt; r.rdy = rdy;
        return r;
    endfunction

    vec_t vecs[20];
    ent_t captured[$];

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_addr     = 3'd0;
        in_data     = 8'h00;
        drain_stall = 1'b0;
        rd_addr     = 3'd0;

        // Expected values are the state just after the edge with the row's inputs.
        //            rst v  a  d      st  we     dat    cnt rdy
        vecs[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1);
        vecs[1]  = mk(0, 1, 3, 8'hA5, 0, 8'h00, 8'h00, 1, 1);
        vecs[2]  = mk(0, 0, 0, 8'h00, 0, 8'h08, 8'hA5, 0, 1);
        vecs[3]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 8'hA5, 0, 1);
        vecs[4]  = mk(0, 1, 1, 8'h11, 1, 8'h00, 8'hA5, 1, 1);
        vecs[5]  = mk(0, 1, 2, 8'h22, 1, 8'h00, 8'hA5, 2, 1);
        vecs[6]  = mk(0, 1, 3, 8'h33, 1, 8'h00, 8'hA5, 3, 1);
        vecs[7]  = mk(0, 1, 4, 8'h44, 1, 8'h00, 8'hA5, 4, 0);
        vecs[8]  = mk(0, 1, 5, 8'h55, 1, 8'h00, 8'hA5, 4, 0);
        vecs[9]  = mk(0, 0, 0, 8'h00, 0, 8'h02, 8'h11, 3, 1);
        vecs[10] = mk(0, 0, 0, 8'h00, 0, 8'h04, 8'h22, 2, 1);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 8'h08, 8'h33, 1, 1);
        vecs[12] = mk(0, 0, 0, 8'h00, 0, 8'h10, 8'h44, 0, 1);
        vecs[13] = mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h44, 0, 1);
        vecs[14] = mk(0, 1, 6, 8'h66, 1, 8'h00, 8'h44, 1, 1);
        vecs[15] = mk(0, 1, 7, 8'h77, 1, 8'h00, 8'h44, 2, 1);
        vecs[16] = mk(0, 1, 0, 8'h80, 1, 8'h00, 8'h44, 3, 1);
        vecs[17] = mk(1, 1, 1, 8'h99, 0, 8'h00, 8'h00, 0, 1);
        vecs[18] = mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1);
        vecs[19] = mk(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1);

        for (int i = 0; i < 20; i++) begin
            reset       = vecs[i].rst;
            in_valid    = vecs[i].v;
            in_addr     = vecs[i].a;
            in_data     = vecs[i].d;
            drain_stall = vecs[i].st;
            step();
            chk($sformatf("vec%0d reg_we", i),   32'(reg_we),   32'(vecs[i].we));
            chk($sformatf("vec%0d reg_data", i), 32'(reg_data), 32'(vecs[i].dat));
            chk($sformatf("vec%0d count", i),    32'(count),    32'(vecs[i].cnt));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
        end
        reset = 1'b0;

        // Back-to-back pushes across pointer wrap.
        drain_stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10);
            in_addr  = 3'(i % 8);
            in_data  = 8'(8'h30 + i);
            step();
            chk("wrap count<=1", 32'(count <= 4'd1), 32'd1);
            if (reg_we != 8'h00) begin
                ent_t e;
                e.data = reg_data;
                e.addr = 3'd0;
                for (int b = 0; b < 8; b++) if (reg_we[b]) e.addr = 3'(b);
                captured.push_back(e);
            end
        end
        in_valid = 1'b0;
        chk("wrap issue count", 32'(captured.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < captured.size()) begin
                chk($sformatf("wrap%0d addr", i), 32'(captured[i].addr), 32'(i % 8));
                chk($sformatf("wrap%0d data", i), 32'(captured[i].data), 32'(8'h30 + i));
            end
        end

        // Two pending writes to the same register while stalled.
        drain_stall = 1'b1;
        in_valid    = 1'b1;
        in_addr     = 3'd5;
        in_data     = 8'h11;
        step();
        in_data     = 8'h22;
        step();
        in_valid    = 1'b0;
        rd_addr     = 3'd5;
        #1;
`ifdef WRITEBACK_BYPASS_EN
        chk("bypass rd_hit",  32'(rd_hit),  32'd1);
        chk("bypass rd_data", 32'(rd_data), 32'h22);
`else
        chk("bypass rd_hit",  32'(rd_hit),  32'd0);
        chk("bypass rd_data", 32'(rd_data), 32'h00);
`endif
        rd_addr = 3'd4;
        #1;
        chk("bypass miss rd_hit", 32'(rd_hit), 32'd0);
        drain_stall = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            in_valid    = ($urandom_range(0, 9) < 6);
            in_addr     = 3'($urandom_range(0, 7));
            in_data     = 8'($urandom_range(0, 255));
            drain_stall = ($urandom_range(0, 9) < 3);
            rd_addr     = 3'($urandom_range(0, 7));
            step();
        end
        reset       = 1'b0;
        in_valid    = 1'b0;
        drain_stall = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
